// File: rtl/l2_refill_queue_pkg.sv
// Shared L2 D-channel response definitions: field widths, opcode constants and
// the packed queue entry layout used by the refill queue.
package l2_refill_queue_pkg;

    localparam int OP_BITS     = 3;
    localparam int SOURCE_BITS = 4;
    localparam int DATA_BITS   = 32;

    localparam logic [OP_BITS-1:0] ACCESS_ACK      = 3'd0;
    localparam logic [OP_BITS-1:0] ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic [OP_BITS-1:0]     opcode;
        logic [SOURCE_BITS-1:0] source;
        logic [DATA_BITS-1:0]   data;
    } resp_entry_t;

    localparam int ENTRY_BITS = OP_BITS + SOURCE_BITS + DATA_BITS;

    function automatic logic op_has_data(input logic [OP_BITS-1:0] op);
        return (op == ACCESS_ACK_DATA);
    endfunction

endpackage

// File: rtl/l2_sync_fifo.sv
// Generic synchronous FIFO with naturally wrapping pointers and an occupancy
// counter; a push while full is accepted only if a pop frees a slot that cycle.
module l2_sync_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int CNT_BITS = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_i,
    input  logic [WIDTH-1:0]    wdata_i,
    input  logic                pop_i,
    output logic [WIDTH-1:0]    rdata_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [CNT_BITS-1:0] count_o
);

    localparam int PTR_BITS = $clog2(DEPTH);

    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic                push_ok;
    logic                pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_BITS'(DEPTH));
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/l2_refill_queue.sv
// Elastic queue behind the non-stallable D-channel sink: buffers responses,
// exports free-slot credits and flags any beat dropped while full.
module l2_refill_queue
    import l2_refill_queue_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int CNT_BITS = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   resp_valid_i,
    input  logic [OP_BITS-1:0]     resp_opcode_i,
    input  logic [SOURCE_BITS-1:0] resp_source_i,
    input  logic [DATA_BITS-1:0]   resp_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [OP_BITS-1:0]     out_opcode_o,
    output logic [SOURCE_BITS-1:0] out_source_o,
    output logic [DATA_BITS-1:0]   out_data_o,
    output logic                   out_has_data_o,
    output logic [CNT_BITS-1:0]    free_slots_o,
    output logic                   overflow_o,
    input  logic                   overflow_clr_i
);

    resp_entry_t         wr_entry;
    resp_entry_t         head;
    logic                full;
    logic                empty;
    logic                pop;
    logic                drop;
    logic [CNT_BITS-1:0] count;
    logic                overflow_q, overflow_d;

    assign wr_entry = {resp_opcode_i, resp_source_i, resp_data_i};

    l2_sync_fifo #(
        .WIDTH    (ENTRY_BITS),
        .DEPTH    (DEPTH),
        .CNT_BITS (CNT_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (resp_valid_i),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign out_valid_o    = ~empty;
    assign pop            = out_valid_o & out_ready_i;
    assign out_opcode_o   = head.opcode;
    assign out_source_o   = head.source;
    assign out_data_o     = head.data;
    assign out_has_data_o = op_has_data(head.opcode);

    // Counter is a register, so credits reflect edge-N traffic from cycle N+1.
    assign free_slots_o = CNT_BITS'(DEPTH) - count;

    // A drop in the same cycle as a clear keeps the flag set.
    assign drop = resp_valid_i & full & ~pop;

    always_comb begin
        overflow_d = overflow_q;
        if (overflow_clr_i) overflow_d = 1'b0;
        if (drop)           overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow_q <= 1'b0;
        else        overflow_q <= overflow_d;
    end

    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_l2_refill_queue.sv
// Directed bench for l2_refill_queue with a scoreboard of expected head entries.
module tb_l2_refill_queue;
    import l2_refill_queue_pkg::*;

    localparam int DEPTH    = 4;
    localparam int CNT_BITS = $clog2(DEPTH) + 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   resp_valid_i;
    logic [OP_BITS-1:0]     resp_opcode_i;
    logic [SOURCE_BITS-1:0] resp_source_i;
    logic [DATA_BITS-1:0]   resp_data_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [OP_BITS-1:0]     out_opcode_o;
    logic [SOURCE_BITS-1:0] out_source_o;
    logic [DATA_BITS-1:0]   out_data_o;
    logic                   out_has_data_o;
    logic [CNT_BITS-1:0]    free_slots_o;
    logic                   overflow_o;
    logic                   overflow_clr_i;

    int n_checks = 0;
    int n_fail   = 0;
    logic [ENTRY_BITS-1:0] sb [$];

    always #5 clk = ~clk;

    l2_refill_queue #(.DEPTH(DEPTH), .CNT_BITS(CNT_BITS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .resp_valid_i   (resp_valid_i),
        .resp_opcode_i  (resp_opcode_i),
        .resp_source_i  (resp_source_i),
        .resp_data_i    (resp_data_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_opcode_o   (out_opcode_o),
        .out_source_o   (out_source_o),
        .out_data_o     (out_data_o),
        .out_has_data_o (out_has_data_o),
        .free_slots_o   (free_slots_o),
        .overflow_o     (overflow_o),
        .overflow_clr_i (overflow_clr_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare the head against the scoreboard whenever a handshake is about
    // to complete, then advance one clock and settle 1 time unit past it.
    task automatic cycle();
        logic [ENTRY_BITS-1:0] e;
        if (out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", 64'(out_source_o), 64'hFFFF);
            end else begin
                e = sb.pop_front();
                check("head_entry", 64'({out_opcode_o, out_source_o, out_data_o}), 64'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [OP_BITS-1:0] op, input logic [SOURCE_BITS-1:0] src,
                         input logic [DATA_BITS-1:0] dat, input bit expect_kept);
        resp_valid_i  = 1'b1;
        resp_opcode_i = op;
        resp_source_i = src;
        resp_data_i   = dat;
        if (expect_kept) sb.push_back({op, src, dat});
    endtask

    task automatic idle();
        resp_valid_i  = 1'b0;
        resp_opcode_i = '0;
        resp_source_i = '0;
        resp_data_i   = '0;
    endtask

    task automatic drain(input string tag);
        out_ready_i = 1'b1;
        for (int g = 0; g < 20 && sb.size() > 0; g++) cycle();
        check(tag, 64'(sb.size()), 64'd0);
        check({tag, "_valid"}, 64'(out_valid_o), 64'd0);
        check({tag, "_free"}, 64'(free_slots_o), 64'd4);
        out_ready_i = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        out_ready_i    = 1'b0;
        overflow_clr_i = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_free", 64'(free_slots_o), 64'd4);
        check("rst_ovf", 64'(overflow_o), 64'd0);
        check("rst_hasdata", 64'(out_has_data_o), 64'd0);
        rst_n = 1'b1;
        cycle();

        // Single beat with no bypass, then accept it.
        drive(3'd1, 4'd5, 32'hA5, 1'b1);
        check("nobypass_valid", 64'(out_valid_o), 64'd0);
        cycle();
        idle();
        check("single_valid", 64'(out_valid_o), 64'd1);
        check("single_hasdata", 64'(out_has_data_o), 64'd1);
        check("single_free", 64'(free_slots_o), 64'd3);
        check("single_src", 64'(out_source_o), 64'd5);
        cycle();
        check("single_hold", 64'(out_valid_o), 64'd1);
        out_ready_i = 1'b1;
        cycle();
        out_ready_i = 1'b0;
        check("single_popped", 64'(out_valid_o), 64'd0);
        check("single_free_after", 64'(free_slots_o), 64'd4);
        check("single_sb", 64'(sb.size()), 64'd0);

        // Streaming through the pointer wrap with the consumer always ready.
        out_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(3'd1, 4'(i), 32'h100 + 32'(i), 1'b1);
            cycle();
            check("stream_free", 64'(free_slots_o == 3 || free_slots_o == 4), 64'd1);
        end
        idle();
        drain("stream_drain");
        check("stream_ovf", 64'(overflow_o), 64'd0);

        // Full queue with push and pop in the same cycle.
        for (int i = 0; i < 4; i++) begin
            drive(3'd1, 4'(8 + i), 32'h200 + 32'(i), 1'b1);
            cycle();
        end
        idle();
        check("full_free", 64'(free_slots_o), 64'd0);
        drive(3'd1, 4'd7, 32'h777, 1'b1);
        out_ready_i = 1'b1;
        cycle();
        idle();
        out_ready_i = 1'b0;
        check("fullpp_free", 64'(free_slots_o), 64'd0);
        check("fullpp_ovf", 64'(overflow_o), 64'd0);
        drain("fullpp_drain");

        // Overflow: fifth beat dropped, flag sticky, stored entries intact.
        for (int i = 0; i < 4; i++) begin
            drive(3'd1, 4'(1 + i), 32'h300 + 32'(i), 1'b1);
            cycle();
        end
        drive(3'd1, 4'd15, 32'hDEAD, 1'b0);
        cycle();
        idle();
        check("ovf_set", 64'(overflow_o), 64'd1);
        check("ovf_free", 64'(free_slots_o), 64'd0);
        cycle();
        check("ovf_sticky", 64'(overflow_o), 64'd1);
        drain("ovf_drain");
        check("ovf_after_drain", 64'(overflow_o), 64'd1);
        overflow_clr_i = 1'b1;
        cycle();
        overflow_clr_i = 1'b0;
        check("ovf_clr", 64'(overflow_o), 64'd0);

        // Drop coinciding with a clear: the set wins.
        for (int i = 0; i < 4; i++) begin
            drive(3'd0, 4'(4 + i), 32'h400 + 32'(i), 1'b1);
            cycle();
        end
        drive(3'd1, 4'd14, 32'hBEEF, 1'b0);
        overflow_clr_i = 1'b1;
        cycle();
        overflow_clr_i = 1'b0;
        idle();
        check("ovf_setwins", 64'(overflow_o), 64'd1);
        drain("setwins_drain");
        overflow_clr_i = 1'b1;
        cycle();
        overflow_clr_i = 1'b0;
        check("ovf_clr2", 64'(overflow_o), 64'd0);

        // Asynchronous reset with three entries queued.
        for (int i = 0; i < 3; i++) begin
            drive(3'd1, 4'(9 + i), 32'h500 + 32'(i), 1'b1);
            cycle();
        end
        idle();
        check("pre_rst_free", 64'(free_slots_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("arst_valid", 64'(out_valid_o), 64'd0);
        check("arst_free", 64'(free_slots_o), 64'd4);
        check("arst_outs", 64'({out_opcode_o, out_source_o, out_data_o}), 64'd0);
        check("arst_hasdata", 64'(out_has_data_o), 64'd0);
        check("arst_ovf", 64'(overflow_o), 64'd0);
        cycle();
        rst_n = 1'b1;
        cycle();

        // Write acknowledge (opcode 0) at the head decodes as no data.
        drive(3'd0, 4'd3, 32'h1234, 1'b1);
        cycle();
        idle();
        check("ack_valid", 64'(out_valid_o), 64'd1);
        check("ack_hasdata", 64'(out_has_data_o), 64'd0);
        drain("ack_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_refill_queue.md
# l2_refill_queue

Elastic response queue directly downstream of the L2 memory-side D-channel sink. The sink has no backpressure (its `d_ready` is tied high) and presents one registered response per cycle. This block captures every response into a small FIFO and re-presents it to the L2 main pipeline over a valid/ready handshake. It also exports a free-slot credit count, which the A-channel issuer uses to bound outstanding memory requests, and a sticky overflow error.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- CNT_BITS, $clog2(DEPTH)+1, width of the credit count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- resp_valid_i  in  1  one response beat presented this cycle; cannot be stalled.
- resp_opcode_i  in  `OP_BITS  D-channel opcode.
- resp_source_i  in  `SOURCE_BITS  D-channel source ID.
- resp_data_i  in  `DATA_BITS  D-channel data.
- out_valid_o  out  1  head entry is valid.
- out_ready_i  in  1  main pipeline accepts the head entry.
- out_opcode_o  out  `OP_BITS  head entry opcode.
- out_source_o  out  `SOURCE_BITS  head entry source ID.
- out_data_o  out  `DATA_BITS  head entry data.
- out_has_data_o  out  1  head opcode == ACCESS_ACK_DATA.
- free_slots_o  out  CNT_BITS  DEPTH minus occupancy.
- overflow_o  out  1  sticky flag: a beat was dropped.
- overflow_clr_i  in  1  synchronous clear of overflow_o.

## Operation
- push = resp_valid_i; pop = out_valid_o & out_ready_i.
- Storage: DEPTH entries of {opcode, source, data}. Write pointer and read pointer are log2(DEPTH) bits and wrap naturally. A CNT_BITS occupancy counter tracks fill level.
- push, not full: write the entry at wr_ptr, then increment wr_ptr.
- pop: increment rd_ptr.
- Counter update: push-only gives +1; pop-only gives −1; push and pop together, or neither, leave it unchanged.
- Full and push in the same cycle as pop: the push is accepted, because the pop frees the slot in that cycle.
- Full and push without pop: the beat is dropped and overflow_o is set. Pointers and counter are unchanged, and stored entries are never corrupted.
- overflow_o clear: overflow_clr_i clears it in the next cycle. If a drop occurs in the same cycle as the clear, set wins.
- Empty: out_valid_o = 0, and out_ready_i is ignored; no pop can occur.
- No bypass: a beat pushed into an empty queue is visible only in the next cycle.
- Ordering: strict FIFO with no reordering by source.
- out_has_data_o is decoded combinationally from the head opcode.
- ACCESS_ACK entries (write acknowledges) flow through the queue exactly like data beats.
- Reset, including mid-operation:
  - pointers = 0, count = 0, storage = 0, overflow_o = 0.
  - out_valid_o = 0, out_opcode_o/out_source_o/out_data_o = 0, out_has_data_o = 0.
  - free_slots_o = DEPTH.
  - Any in-flight entries are discarded.

## Timing
- Latency: a push at edge N makes out_valid_o = 1 after edge N, with the data held stable until popped.
- Head outputs are combinational reads of storage[rd_ptr]; they update one cycle after the pop edge.
- free_slots_o is registered, derived from the counter, and reflects edge-N pushes and pops from cycle N+1.
- Throughput: one push and one pop per cycle sustained, with occupancy constant.
- out_valid_o never drops while out_ready_i = 0. Head data is stable until accepted.

## Structure
- Opcode constants ACCESS_ACK = 0 and ACCESS_ACK_DATA = 1 go in the shared L2 define file. `OP_BITS, `SOURCE_BITS and `DATA_BITS come from define.v.
- One natural sub-module: l2_sync_fifo, a generic parameterised width/depth FIFO with push, pop, full, empty and count. The top level adds opcode decode, overflow handling and credit output.

## Test plan
- Single beat:
  - Stimulus: reset, then push opcode=1, source=5, data=0xA5 with out_ready_i = 0.
  - Response: out_valid_o = 1 one cycle later, with out_has_data_o = 1 and free_slots_o = 3.
  - Then raise out_ready_i: out_valid_o = 0 the next cycle and free_slots_o = 4.
- Ordering and wrap:
  - Stimulus: push sources 0..9 on consecutive cycles with out_ready_i = 1.
  - Response: outputs are sources 0..9 in order, free_slots_o stays at 3–4, and overflow_o = 0.
- Full plus simultaneous push/pop:
  - Stimulus: fill 4 entries with out_ready_i = 0, then push source 7 in the same cycle out_ready_i = 1.
  - Response: the beat is accepted, count stays 4, and overflow_o = 0.
- Overflow:
  - Stimulus: fill 4 entries and push a 5th with out_ready_i = 0.
  - Response: overflow_o = 1 and sticky. Draining returns exactly the first 4 entries.
  - Then assert overflow_clr_i: overflow_o = 0 the next cycle.
- Reset mid-operation:
  - Stimulus: with 3 entries queued, pulse rst_n low asynchronously.
  - Response: out_valid_o = 0 immediately, free_slots_o = 4, and all out_* = 0.
- Opcode decode:
  - Stimulus: push opcode 0.
  - Response: out_has_data_o = 0 while the entry is at the head.
